// File: rtl/oven_sequencer_if.sv
// oven_sequencer_if: control, sensor and status bundle of the oven sequencer
//   master: drives power, buttons and cur_temp; observes status
//   slave : the sequencer; drives heat_en, target_temp, time_left, state, done, tick
interface oven_sequencer_if;
  logic        power;
  logic        start;
  logic        cancel;
  logic        temp_up;
  logic        temp_dn;
  logic        time_up;
  logic        time_dn;
  logic [10:0] cur_temp;
  logic        heat_en;
  logic [10:0] target_temp;
  logic [11:0] time_left;
  logic [2:0]  state;
  logic        done;
  logic        tick;
  modport master (
    output power, start, cancel, temp_up, temp_dn, time_up, time_dn, cur_temp,
    input  heat_en, target_temp, time_left, state, done, tick
  );
  modport slave (
    input  power, start, cancel, temp_up, temp_dn, time_up, time_dn, cur_temp,
    output heat_en, target_temp, time_left, state, done, tick
  );
endinterface

// File: rtl/oven_sequencer.sv
// oven_sequencer: oven setpoint/timer FSM with hysteresis thermostat and 1 Hz tick
//   clk, rst_n : clock, async active-low reset
//   bus        : oven_sequencer_if.slave (power, buttons, cur_temp in; heat_en,
//                target_temp, time_left, state, done, tick out)
module oven_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int TEMP_MIN = 60,
  parameter int TEMP_MAX = 900,
  parameter int HYST     = 5,
  parameter int TIME_MAX = 3600
) (
  input logic             clk,
  input logic             rst_n,
  oven_sequencer_if.slave bus
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_IDLE    = 3'd1,
    S_PREHEAT = 3'd2,
    S_BAKE    = 3'd3,
    S_DONE    = 3'd4
  } state_e;
  state_e        state_q, state_d;
  logic          heat_q, heat_d, done_q, done_d, tick_q;
  logic [10:0]   target_q, target_d, tgt_inc, tgt_dec, tgt_adj;
  logic [11:0]   time_q, time_d, t_base, t_inc, t_dec, t_adj;
  logic [CW-1:0] cnt_q;
  logic [5:0]    btn, btn_q, edg;
  logic          warm, hot;
  assign btn = {bus.start, bus.cancel, bus.temp_up, bus.temp_dn, bus.time_up, bus.time_dn};
  assign edg = btn & ~btn_q;
  // cur >= target-HYST, rearranged so the subtraction can never wrap
  assign warm = {1'b0, bus.cur_temp} + 12'(HYST) >= {1'b0, target_q};
  assign hot  = bus.cur_temp >= target_q;
  assign tgt_inc = target_q + 11'd10 > 11'(TEMP_MAX) ? 11'(TEMP_MAX) : target_q + 11'd10;
  assign tgt_dec = target_q < 11'(TEMP_MIN + 10) ? 11'(TEMP_MIN) : target_q - 11'd10;
  assign tgt_adj = edg[3] ^ edg[2] ? (edg[3] ? tgt_inc : tgt_dec) : target_q;
  // tick decrement lands first, then the button adjustment and its clamp
  assign t_base = state_q == S_BAKE && tick_q && time_q != 12'd0 ? time_q - 12'd1 : time_q;
  assign t_inc  = t_base + 12'd60 > 12'(TIME_MAX) ? 12'(TIME_MAX) : t_base + 12'd60;
  assign t_dec  = t_base < 12'd60 ? t_base : t_base - 12'd60;
  assign t_adj  = edg[1] ^ edg[0] ? (edg[1] ? t_inc : t_dec) : t_base;
  always_comb begin
    state_d  = state_q;
    heat_d   = heat_q;
    done_d   = done_q;
    target_d = target_q;
    time_d   = time_q;
    if (!bus.power) begin
      state_d = S_OFF;
      heat_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_IDLE;
        S_IDLE: begin
          target_d = tgt_adj;
          time_d   = t_adj;
          if (edg[5] && time_q != 12'd0) begin
            state_d = S_PREHEAT;
            heat_d  = 1'b1;
          end
        end
        S_PREHEAT: begin
          if (edg[4]) begin
            state_d = S_IDLE;
            heat_d  = 1'b0;
            time_d  = '0;
          end else if (warm) begin
            state_d = S_BAKE;
            heat_d  = !hot;
          end
        end
        S_BAKE: begin
          if (edg[4]) begin
            state_d = S_IDLE;
            heat_d  = 1'b0;
            time_d  = '0;
          end else begin
            time_d = t_adj;
            heat_d = !warm ? 1'b1 : hot ? 1'b0 : heat_q;
            if (t_adj == 12'd0) begin
              state_d = S_DONE;
              heat_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (|edg) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      heat_q   <= 1'b0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
      target_q <= 11'd300;
      time_q   <= '0;
      cnt_q    <= '0;
      btn_q    <= '0;
    end else begin
      state_q  <= state_d;
      heat_q   <= heat_d;
      done_q   <= done_d;
      tick_q   <= cnt_q == CNT_LAST;
      target_q <= target_d;
      time_q   <= time_d;
      cnt_q    <= cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
      btn_q    <= btn;
    end
  end
  assign bus.state       = state_q;
  assign bus.heat_en     = heat_q;
  assign bus.done        = done_q;
  assign bus.tick        = tick_q;
  assign bus.target_temp = target_q;
  assign bus.time_left   = time_q;
endmodule

// File: tb/tb_oven_sequencer.sv
// tb_oven_sequencer: directed and random checks of oven_sequencer against a reference model
module tb_oven_sequencer;
  localparam int TD = 4;
  localparam int TMIN = 60;
  localparam int TMAX = 900;
  localparam int HY = 5;
  localparam int TIMX = 3600;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int m_state, m_target, m_time, m_n;
  bit m_heat, m_done, m_tick;
  bit [5:0] m_prev;
  int held_t;
  oven_sequencer_if bus();
  oven_sequencer #(.TICK_DIV(TD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int adj_time(input int t, input bit up, input bit dn);
    if (up && !dn) return (t + 60 > TIMX) ? TIMX : t + 60;
    if (dn && !up) return (t < 60) ? t : t - 60;
    return t;
  endfunction
  task automatic model_reset();
    m_state = 0; m_heat = 0; m_done = 0; m_tick = 0;
    m_target = 300; m_time = 0; m_n = 0; m_prev = '0;
  endtask
  task automatic model_step();
    bit [5:0] cur, e;
    bit tick_before, start_ok;
    int t, thr;
    cur = {bus.start, bus.cancel, bus.temp_up, bus.temp_dn, bus.time_up, bus.time_dn};
    e = cur & ~m_prev;
    m_prev = cur;
    tick_before = m_tick;
    m_n++;
    m_tick = (m_n % TD == 0);
    thr = m_target - HY;
    if (!bus.power) begin
      m_state = 0; m_heat = 0; m_done = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      start_ok = e[5] && m_time > 0;
      if (e[3] && !e[2]) m_target = (m_target + 10 > TMAX) ? TMAX : m_target + 10;
      if (e[2] && !e[3]) m_target = (m_target - 10 < TMIN) ? TMIN : m_target - 10;
      m_time = adj_time(m_time, e[1], e[0]);
      if (start_ok) begin m_state = 2; m_heat = 1; end
    end else if (m_state == 2) begin
      if (e[4]) begin m_state = 1; m_heat = 0; m_time = 0; end
      else if (int'(bus.cur_temp) >= thr) begin
        m_state = 3;
        m_heat = int'(bus.cur_temp) < m_target;
      end
    end else if (m_state == 3) begin
      if (e[4]) begin m_state = 1; m_heat = 0; m_time = 0; end
      else begin
        t = (tick_before && m_time > 0) ? m_time - 1 : m_time;
        m_time = adj_time(t, e[1], e[0]);
        if (int'(bus.cur_temp) < thr) m_heat = 1;
        else if (int'(bus.cur_temp) >= m_target) m_heat = 0;
        if (m_time == 0) begin m_state = 4; m_heat = 0; m_done = 1; end
      end
    end else if (m_state == 4) begin
      if (e != 0) begin m_state = 1; m_done = 0; end
    end
  endtask
  task automatic check_all();
    chk("state", 32'(bus.state), m_state);
    chk("heat_en", 32'(bus.heat_en), int'(m_heat));
    chk("done", 32'(bus.done), int'(m_done));
    chk("tick", 32'(bus.tick), int'(m_tick));
    chk("target_temp", 32'(bus.target_temp), m_target);
    chk("time_left", 32'(bus.time_left), m_time);
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic set_btn(input int idx, input bit v);
    case (idx)
      0: bus.start = v;
      1: bus.cancel = v;
      2: bus.temp_up = v;
      3: bus.temp_dn = v;
      4: bus.time_up = v;
      default: bus.time_dn = v;
    endcase
  endtask
  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    step();
    set_btn(idx, 1'b0);
    step();
  endtask
  task automatic clear_inputs();
    bus.start = 0; bus.cancel = 0; bus.temp_up = 0; bus.temp_dn = 0;
    bus.time_up = 0; bus.time_dn = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    clear_inputs();
    bus.power = 0;
    bus.cur_temp = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check_all();
    bus.power = 1;
    for (int i = 0; i < TD - 1; i++) begin
      step();
      chk("pre_tick", 32'(bus.tick), 0);
    end
    step();
    chk("first_tick", 32'(bus.tick), 1);
    repeat (3) press(2);
    chk("t330", 32'(bus.target_temp), 330);
    chk("idle", 32'(bus.state), 1);
    repeat (3) press(3);
    repeat (59) press(2);
    chk("t890", 32'(bus.target_temp), 890);
    press(2);
    press(2);
    chk("t900_clamp", 32'(bus.target_temp), 900);
    repeat (83) press(3);
    chk("t70", 32'(bus.target_temp), 70);
    press(3);
    press(3);
    chk("t60_clamp", 32'(bus.target_temp), 60);
    repeat (24) press(2);
    chk("t300", 32'(bus.target_temp), 300);
    press(4);
    chk("time60", 32'(bus.time_left), 60);
    bus.cur_temp = 200;
    press(0);
    chk("preheat", 32'(bus.state), 2);
    chk("preheat_heat", 32'(bus.heat_en), 1);
    bus.cur_temp = 295;
    step();
    chk("bake", 32'(bus.state), 3);
    bus.cur_temp = 294; step(); chk("heat_294", 32'(bus.heat_en), 1);
    bus.cur_temp = 297; step(); chk("heat_297_hold1", 32'(bus.heat_en), 1);
    bus.cur_temp = 300; step(); chk("heat_300", 32'(bus.heat_en), 0);
    bus.cur_temp = 297; step(); chk("heat_297_hold0", 32'(bus.heat_en), 0);
    for (int i = 0; i < 400 && m_state != 4; i++) step();
    chk("done_state", 32'(bus.state), 4);
    chk("done_flag", 32'(bus.done), 1);
    chk("done_heat", 32'(bus.heat_en), 0);
    press(1);
    chk("done_exit", 32'(bus.state), 1);
    chk("done_exit_target", 32'(bus.target_temp), 300);
    repeat (61) press(4);
    chk("time3600", 32'(bus.time_left), 3600);
    bus.cur_temp = 300;
    press(0);
    chk("bake2", 32'(bus.state), 3);
    for (int i = 0; i < 200 && !(m_time == 3590 && m_tick); i++) step();
    chk("at3590", 32'(bus.time_left), 3590);
    bus.time_up = 1;
    step();
    chk("tick_up_clamp", 32'(bus.time_left), 3600);
    bus.time_up = 0;
    step();
    for (int i = 0; i < 100 && m_time >= 120; i++) press(5);
    for (int i = 0; i < 2000 && !(m_time == 30 && !m_tick); i++) step();
    bus.time_dn = 1;
    step();
    chk("dn_ignored", 32'(bus.time_left), 30);
    bus.time_dn = 0;
    bus.cur_temp = 200;
    step();
    chk("bake_heat", 32'(bus.heat_en), 1);
    held_t = m_time;
    bus.power = 0;
    step();
    chk("off_state", 32'(bus.state), 0);
    chk("off_heat", 32'(bus.heat_en), 0);
    chk("off_time_held", 32'(bus.time_left), held_t);
    bus.power = 1;
    step();
    press(0);
    bus.cur_temp = 295;
    step();
    bus.cur_temp = 200;
    step();
    chk("bake3", 32'(bus.state), 3);
    chk("bake3_heat", 32'(bus.heat_en), 1);
    #3;
    rst_n = 0;
    #1;
    chk("async_heat", 32'(bus.heat_en), 0);
    chk("async_state", 32'(bus.state), 0);
    chk("async_target", 32'(bus.target_temp), 300);
    chk("async_time", 32'(bus.time_left), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    check_all();
    for (int i = 0; i < 800; i++) begin
      bus.power    = $urandom_range(0, 49) != 0;
      bus.start    = $urandom_range(0, 3) == 0;
      bus.cancel   = $urandom_range(0, 15) == 0;
      bus.temp_up  = $urandom_range(0, 3) == 0;
      bus.temp_dn  = $urandom_range(0, 3) == 0;
      bus.time_up  = $urandom_range(0, 2) == 0;
      bus.time_dn  = $urandom_range(0, 5) == 0;
      bus.cur_temp = 11'(m_target - 12 + int'($urandom_range(0, 20)));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
